// File: rtl/adc_source_selector.sv
`default_nettype none
// ============================================================================
// Module   : adc_source_selector
// Purpose  : Selects regular or successive ADC samples per channel, with a
//            blanking interval after every mode change.
// Revision : 1.0 - initial release
// ============================================================================
module adc_source_selector #(
   parameter int WIDTH        = 8,
   parameter int CHANNELS     = 2,
   parameter int BLANK_CYCLES = 4
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic [1:0]                mode_i,
   input  logic [CHANNELS-1:0]       ch_en_i,
   input  logic [CHANNELS*WIDTH-1:0] reg_data_i,
   input  logic [CHANNELS-1:0]       reg_valid_i,
   input  logic [CHANNELS*WIDTH-1:0] succ_data_i,
   input  logic [CHANNELS-1:0]       succ_valid_i,
   output logic [CHANNELS*WIDTH-1:0] out_data_o,
   output logic [CHANNELS-1:0]       out_valid_o,
   output logic [1:0]                active_mode_o,
   output logic                      blanking_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_PASS  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_REG   = 2'b01;
   localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES - 1);

   state_t                    state_q;
   logic [1:0]                active_mode_q;
   logic [7:0]                blank_cnt_q;
   logic [CHANNELS*WIDTH-1:0] out_data_q;
   logic [CHANNELS-1:0]       out_valid_q;
   logic                      blanking_q;

   logic [1:0]                mode_norm;
   logic [CHANNELS-1:0]       sel_valid;
   logic [CHANNELS*WIDTH-1:0] sel_data;

   // Reserved encoding 11 behaves exactly like OFF.
   assign mode_norm = (mode_i == 2'b11) ? MODE_OFF : mode_i;
   assign sel_valid = (active_mode_q == MODE_REG) ? reg_valid_i : succ_valid_i;
   assign sel_data  = (active_mode_q == MODE_REG) ? reg_data_i  : succ_data_i;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q       <= S_IDLE;
         active_mode_q <= MODE_OFF;
         blank_cnt_q   <= '0;
         out_data_q    <= '0;
         out_valid_q   <= '0;
         blanking_q    <= 1'b0;
      end else if (mode_norm != active_mode_q) begin
         // Any change discards same-cycle strobes and wipes the held samples.
         active_mode_q <= mode_norm;
         out_data_q    <= '0;
         out_valid_q   <= '0;
         if (mode_norm == MODE_OFF) begin
            state_q     <= S_IDLE;
            blank_cnt_q <= '0;
            blanking_q  <= 1'b0;
         end else begin
            state_q     <= S_BLANK;
            blank_cnt_q <= BLANK_LOAD;
            blanking_q  <= 1'b1;
         end
      end else begin
         out_valid_q <= '0;
         case (state_q)
            S_IDLE: begin
               blanking_q <= 1'b0;
            end
            S_BLANK: begin
               if (blank_cnt_q == 8'd0) begin
                  state_q    <= S_PASS;
                  blanking_q <= 1'b0;
               end else begin
                  blank_cnt_q <= blank_cnt_q - 8'd1;
               end
            end
            S_PASS: begin
               for (int i = 0; i < CHANNELS; i++) begin
                  if (ch_en_i[i] && sel_valid[i]) begin
                     out_data_q[i*WIDTH +: WIDTH] <= sel_data[i*WIDTH +: WIDTH];
                     out_valid_q[i]               <= 1'b1;
                  end
               end
            end
            default: begin
               state_q    <= S_IDLE;
               blanking_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_data_o    = out_data_q;
   assign out_valid_o   = out_valid_q;
   assign active_mode_o = active_mode_q;
   assign blanking_o    = blanking_q;

endmodule
`default_nettype wire
